counter_x: RTL and testbench

COUNTER_X -- requirements
Module: counter_x

---
 rtl/mio_counter_pkg.sv | 41 ++++
 rtl/counter_chan.sv | 50 +++++
 rtl/counter_x.sv | 80 ++++++++
 tb/tb_counter_x.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mio_counter_pkg.sv
// Shared constants for the three-channel down-counter peripheral.
// Optional prescaler feature: COUNTER_PRESCALE_EN.
package mio_counter_pkg;

    localparam int DATA_W   = 32;
    localparam int N_CHAN   = 3;

    typedef enum logic [1:0] {
        ONESHOT     = 2'b00,
        PERIODIC    = 2'b01,
        SQUARE      = 2'b10,
        ONESHOT_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CH0  = 2'd0,
        CH1  = 2'd1,
        CH2  = 2'd2,
        CTRL = 2'd3
    } reg_e;

    localparam int EN_LSB   = 0;
    localparam int MODE_LSB = 4;
    localparam int MODE_W   = 2;
    localparam int DIV_LSB  = 16;
    localparam int DIV_W    = 16;

`ifdef COUNTER_PRESCALE_EN
    localparam logic [DATA_W-1:0] CTRL_MASK = 32'hFFFF_03F7;
`else
    localparam logic [DATA_W-1:0] CTRL_MASK = 32'h0000_03F7;
`endif

    function automatic logic [MODE_W-1:0] chan_mode(
        input logic [DATA_W-1:0] ctrl,
        input int                n
    );
        return ctrl[MODE_LSB + MODE_W*n +: MODE_W];
    endfunction

endpackage

// File: rtl/counter_chan.sv
// One down-counter channel: reload R, live count C, event output O.
// Bus load always wins over a tick or terminal event in the same cycle.
module counter_chan
    import mio_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              tick,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] count,
    output logic              out
);

    logic [DATA_W-1:0] reload;
    logic              run;
    logic              evt;
    logic              rearm;
    mode_e             mode_q;

    assign mode_q = mode_e'(mode);
    assign run    = enable && (reload != '0);
    assign evt    = run && tick && (count == DATA_W'(1));
    assign rearm  = (mode_q == PERIODIC) || (mode_q == SQUARE);

    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= '0;
            count  <= '0;
            out    <= 1'b0;
        end else if (load) begin
            reload <= load_data;
            count  <= load_data;
            out    <= 1'b0;
        end else if (run) begin
            if (tick && (count != '0)) begin
                count <= (evt && rearm) ? reload : count - DATA_W'(1);
            end
            // Periodic pulse drops on the following cycle even without a tick
            unique case (mode_q)
                PERIODIC: out <= evt;
                SQUARE:   out <= out ^ evt;
                default:  out <= out | evt;
            endcase
        end
    end

endmodule

// File: rtl/counter_x.sv
// Three-channel timer peripheral: write decode, control register,
// shared prescaler (COUNTER_PRESCALE_EN) and register read mux.
module counter_x
    import mio_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              counter_we,
    input  logic [1:0]        counter_ch,
    input  logic [DATA_W-1:0] Peripheral_in,
    output logic [DATA_W-1:0] counter_out,
    output logic              counter0_out,
    output logic              counter1_out,
    output logic              counter2_out
);

    logic [DATA_W-1:0] ctrl;
    logic              ctrl_we;
    logic              tick;
    logic [DATA_W-1:0] cnt [N_CHAN];
    logic [N_CHAN-1:0] chan_out;

    assign ctrl_we = counter_we && (reg_e'(counter_ch) == CTRL);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= Peripheral_in & CTRL_MASK;
        end
    end

`ifdef COUNTER_PRESCALE_EN
    logic [DIV_W-1:0] pre;

    assign tick = (pre == ctrl[DIV_LSB +: DIV_W]);

    // A control write restarts the divide sequence from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (ctrl_we || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + DIV_W'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        counter_chan u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (counter_we && (counter_ch == 2'(i))),
            .load_data (Peripheral_in),
            .tick      (tick),
            .enable    (ctrl[EN_LSB + i]),
            .mode      (chan_mode(ctrl, i)),
            .count     (cnt[i]),
            .out       (chan_out[i])
        );
    end

    assign counter0_out = chan_out[0];
    assign counter1_out = chan_out[1];
    assign counter2_out = chan_out[2];

    always_comb begin
        counter_out = '0;
        unique case (reg_e'(counter_ch))
            CH0:  counter_out = cnt[0];
            CH1:  counter_out = cnt[1];
            CH2:  counter_out = cnt[2];
            CTRL: counter_out = ctrl;
        endcase
    end

endmodule

// File: tb/tb_counter_x.sv
// Directed-vector bench for counter_x.
// Prescaler vectors run only when COUNTER_PRESCALE_EN is defined.
module tb_counter_x;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        counter_we = 1'b0;
    logic [1:0]  counter_ch = 2'd0;
    logic [31:0] Peripheral_in = '0;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    int vectors = 0;
    int miscompares = 0;

    counter_x dut (
        .clk           (clk),
        .rst           (rst),
        .counter_we    (counter_we),
        .counter_ch    (counter_ch),
        .Peripheral_in (Peripheral_in),
        .counter_out   (counter_out),
        .counter0_out  (counter0_out),
        .counter1_out  (counter1_out),
        .counter2_out  (counter2_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] d);
        counter_we    = 1'b1;
        counter_ch    = ch;
        Peripheral_in = d;
        cyc();
        counter_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] ch,
                      input logic [31:0] exp);
        counter_ch = ch;
        #1;
        chk(tag, counter_out, exp);
    endtask

    initial begin
        logic [31:0] c1_seq [6];
        logic        o1_seq [6];
        logic [31:0] c2_seq [6];
        logic        o2_seq [6];
        logic [31:0] ctrl_hi;

        c1_seq = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};
        o1_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        c2_seq = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
        o2_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rd($sformatf("rst_rd%0d", i), 2'(i), 32'd0);
        chk("rst_o0", 32'(counter0_out), 32'd0);
        chk("rst_o1", 32'(counter1_out), 32'd0);
        chk("rst_o2", 32'(counter2_out), 32'd0);

        // ch0 one-shot, reload 5
        wr(2'd0, 32'd5);
        rd("os_load", 2'd0, 32'd5);
        wr(2'd3, 32'h0000_0001);
        rd("os_ctrl_noc", 2'd0, 32'd5);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            rd($sformatf("os_c%0d", i), 2'd0, 32'(i));
            chk($sformatf("os_o%0d", i), 32'(counter0_out),
                (i == 0) ? 32'd1 : 32'd0);
        end
        cyc();
        cyc();
        rd("os_hold_c", 2'd0, 32'd0);
        chk("os_hold_o", 32'(counter0_out), 32'd1);

        // ch1 periodic, reload 3
        wr(2'd1, 32'd3);
        wr(2'd3, 32'h0000_0043);
        counter_ch = 2'd1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            rd($sformatf("per_c%0d", i), 2'd1, c1_seq[i]);
            chk($sformatf("per_o%0d", i), 32'(counter1_out), 32'(o1_seq[i]));
        end

        // ch2 square, reload 2
        wr(2'd2, 32'd2);
        wr(2'd3, 32'h0000_0247);
        rd("sq_ctrl_rd", 2'd3, 32'h0000_0247);
        for (int i = 0; i < 6; i++) begin
            cyc();
            rd($sformatf("sq_c%0d", i), 2'd2, c2_seq[i]);
            chk($sformatf("sq_o%0d", i), 32'(counter2_out), 32'(o2_seq[i]));
        end

        // write on the terminal-event cycle wins
        wr(2'd0, 32'd3);
        chk("we_o_clr", 32'(counter0_out), 32'd0);
        cyc();
        cyc();
        rd("we_pre", 2'd0, 32'd1);
        wr(2'd0, 32'd10);
        rd("we_load", 2'd0, 32'd10);
        chk("we_no_evt", 32'(counter0_out), 32'd0);

        // disable ch0 freezes it; upper ctrl bits
        wr(2'd3, 32'hFFFF_0A46);
        rd("dis_c", 2'd0, 32'd9);
        cyc();
        cyc();
        rd("dis_hold", 2'd0, 32'd9);
`ifdef COUNTER_PRESCALE_EN
        ctrl_hi = 32'hFFFF_0246;
`else
        ctrl_hi = 32'h0000_0246;
`endif
        rd("ctrl_mask", 2'd3, ctrl_hi);

        // reload 0 on an enabled channel holds with no event
        wr(2'd1, 32'd0);
        cyc();
        cyc();
        rd("r0_c", 2'd1, 32'd0);
        chk("r0_o", 32'(counter1_out), 32'd0);

`ifdef COUNTER_PRESCALE_EN
        // D = 3: tick every 4 cycles, event 8 cycles after enable
        wr(2'd0, 32'd2);
        wr(2'd3, 32'h0003_0001);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            rd($sformatf("pre_c%0d", k), 2'd0,
               (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0);
            chk($sformatf("pre_o%0d", k), 32'(counter0_out),
                (k == 8) ? 32'd1 : 32'd0);
        end
`endif

        // reset mid-count overrides a concurrent write
        wr(2'd0, 32'd100);
        wr(2'd3, 32'h0000_0247);
        wr(2'd2, 32'd7);
        cyc();
        cyc();
        rst           = 1'b1;
        counter_we    = 1'b1;
        counter_ch    = 2'd2;
        Peripheral_in = 32'd55;
        cyc();
        rst        = 1'b0;
        counter_we = 1'b0;
        for (int i = 0; i < 4; i++) rd($sformatf("mrst_rd%0d", i), 2'(i), 32'd0);
        chk("mrst_o0", 32'(counter0_out), 32'd0);
        chk("mrst_o1", 32'(counter1_out), 32'd0);
        chk("mrst_o2", 32'(counter2_out), 32'd0);
        cyc();
        rd("mrst_stay", 2'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
